apb_fsm_controller: RTL and testbench

APB_FSM_CONTROLLER -- requirements
Module: apb_fsm_controller

---
 rtl/apb_fsm_controller.sv | 138 +++++++++++++
 tb/tb_apb_fsm_controller.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller
//   AHB-to-APB bridge controller. Decodes an AHB address-phase transfer onto
//   one of three APB slaves and runs a Moore FSM through the APB setup and
//   access phases, stalling the AHB data phase with hready_out.
//
// Ports
//   hclk        in   clock, all state changes on rising edge
//   hreset      in   asynchronous active-high reset
//   valid       in   AHB transfer present in the address phase
//   hwrite      in   1 = write, 0 = read (qualified by valid)
//   haddr       in   [31:0] AHB address (address phase)
//   hwdata      in   [31:0] AHB write data (data phase)
//   prdata      in   [31:0] APB read data
//   pwrite      out  APB direction
//   penable     out  APB access phase
//   psel        out  [2:0] one-hot APB slave select
//   paddr       out  [31:0] APB address
//   pwdata      out  [31:0] APB write data
//   hready_out  out  1 = current AHB data phase completes this cycle
//   hrdata      out  [31:0] AHB read data
module apb_fsm_controller (
   input  logic        hclk,
   input  logic        hreset,
   input  logic        valid,
   input  logic        hwrite,
   input  logic [31:0] haddr,
   input  logic [31:0] hwdata,
   input  logic [31:0] prdata,
   output logic        pwrite,
   output logic        penable,
   output logic [2:0]  psel,
   output logic [31:0] paddr,
   output logic [31:0] pwdata,
   output logic        hready_out,
   output logic [31:0] hrdata
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      READ    = 3'd1,
      RENABLE = 3'd2,
      WWAIT   = 3'd3,
      WRITE   = 3'd4,
      WENABLE = 3'd5
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] addr_q, data_q;
   logic        write_q;
   logic [2:0]  sel_q;
   logic [2:0]  sel_dec;
   logic        accept;

   // Each slave owns a 64 MB window selected by haddr[31:26].
   always_comb begin
      sel_dec = 3'b000;
      case (haddr[31:26])
         6'b100000: sel_dec = 3'b001;
         6'b100001: sel_dec = 3'b010;
         6'b100010: sel_dec = 3'b100;
         default:   sel_dec = 3'b000;
      endcase
   end

   // hready_out is a pure function of state, so gating accept with it keeps
   // the address phase from being taken while a data phase is stalled.
   assign accept = valid & hready_out & (|sel_dec);

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state   <= IDLE;
         addr_q  <= '0;
         write_q <= 1'b0;
         sel_q   <= '0;
         data_q  <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            addr_q  <= haddr;
            write_q <= hwrite;
            sel_q   <= sel_dec;
         end
         // Write data arrives one cycle after the address phase.
         if (state == WWAIT)
            data_q <= hwdata;
      end
   end

   always_comb begin
      state_nxt  = state;
      psel       = 3'b000;
      penable    = 1'b0;
      pwrite     = 1'b0;
      hready_out = 1'b1;
      hrdata     = 32'h0;
      case (state)
         // RENABLE and WENABLE complete the data phase and may take the
         // next address phase, giving back-to-back transfers with no gap.
         IDLE: begin
            if (accept) state_nxt = hwrite ? WWAIT : READ;
         end
         READ: begin
            psel       = sel_q;
            hready_out = 1'b0;
            state_nxt  = RENABLE;
         end
         RENABLE: begin
            psel    = sel_q;
            penable = 1'b1;
            hrdata  = prdata;
            if (accept) state_nxt = hwrite ? WWAIT : READ;
            else        state_nxt = IDLE;
         end
         WWAIT: begin
            hready_out = 1'b0;
            state_nxt  = WRITE;
         end
         WRITE: begin
            psel       = sel_q;
            pwrite     = write_q;
            hready_out = 1'b0;
            state_nxt  = WENABLE;
         end
         WENABLE: begin
            psel    = sel_q;
            penable = 1'b1;
            pwrite  = write_q;
            if (accept) state_nxt = hwrite ? WWAIT : READ;
            else        state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign paddr  = addr_q;
   assign pwdata = data_q;

endmodule

// File: tb/tb_apb_fsm_controller.sv
// tb_apb_fsm_controller
//   Directed bench for apb_fsm_controller. Inputs are driven 1 ns after the
//   rising edge and outputs are checked at that point, away from the edge.
module tb_apb_fsm_controller;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        valid;
   logic        hwrite;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic [31:0] prdata;
   logic        pwrite;
   logic        penable;
   logic [2:0]  psel;
   logic [31:0] paddr;
   logic [31:0] pwdata;
   logic        hready_out;
   logic [31:0] hrdata;

   int n_cmp = 0;
   int n_bad = 0;

   apb_fsm_controller dut (
      .hclk       (hclk),
      .hreset     (hreset),
      .valid      (valid),
      .hwrite     (hwrite),
      .haddr      (haddr),
      .hwdata     (hwdata),
      .prdata     (prdata),
      .pwrite     (pwrite),
      .penable    (penable),
      .psel       (psel),
      .paddr      (paddr),
      .pwdata     (pwdata),
      .hready_out (hready_out),
      .hrdata     (hrdata)
   );

   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   // Checks the control outputs in one go.
   task automatic ctl(input string tag, input logic [2:0] s, input logic en,
                      input logic wr, input logic rdy);
      chk({tag, ".psel"},    {29'd0, psel},       {29'd0, s});
      chk({tag, ".penable"}, {31'd0, penable},    {31'd0, en});
      chk({tag, ".pwrite"},  {31'd0, pwrite},     {31'd0, wr});
      chk({tag, ".hready"},  {31'd0, hready_out}, {31'd0, rdy});
   endtask

   initial begin
      hreset = 1'b1; valid = 1'b0; hwrite = 1'b0;
      haddr = '0; hwdata = '0; prdata = '0;
      #1;
      ctl("rst", 3'b000, 1'b0, 1'b0, 1'b1);
      chk("rst.paddr",  paddr,  32'h0);
      chk("rst.pwdata", pwdata, 32'h0);
      chk("rst.hrdata", hrdata, 32'h0);
      step(); step();
      hreset = 1'b0;
      step();

      // single read
      valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0010; prdata = 32'h5A;
      step(); valid = 1'b0; haddr = '0; #1;
      ctl("rd.c1", 3'b001, 1'b0, 1'b0, 1'b0);
      chk("rd.c1.paddr",  paddr,  32'h8000_0010);
      chk("rd.c1.hrdata", hrdata, 32'h0);
      step();
      ctl("rd.c2", 3'b001, 1'b1, 1'b0, 1'b1);
      chk("rd.c2.hrdata", hrdata, 32'h5A);
      step();
      ctl("rd.c3", 3'b000, 1'b0, 1'b0, 1'b1);
      chk("rd.c3.hrdata", hrdata, 32'h0);

      // single write; a hit held on valid during WWAIT must be ignored
      valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0004;
      step(); hwrite = 1'b0; haddr = 32'h8800_0000; hwdata = 32'hDEAD_BEEF; #1;
      ctl("wr.wwait", 3'b000, 1'b0, 1'b0, 1'b0);
      step(); valid = 1'b0; hwdata = '0; #1;
      ctl("wr.write", 3'b010, 1'b0, 1'b1, 1'b0);
      chk("wr.write.pwdata", pwdata, 32'hDEAD_BEEF);
      chk("wr.write.paddr",  paddr,  32'h8400_0004);
      step();
      ctl("wr.wen", 3'b010, 1'b1, 1'b1, 1'b1);
      chk("wr.wen.pwdata", pwdata, 32'hDEAD_BEEF);
      step();
      ctl("wr.idle", 3'b000, 1'b0, 1'b0, 1'b1);

      // back-to-back write then read
      valid = 1'b1; hwrite = 1'b1; haddr = 32'h8800_0000;
      step(); valid = 1'b0; hwdata = 32'h1234_5678; #1;
      step();
      ctl("b2b.write", 3'b100, 1'b0, 1'b1, 1'b0);
      chk("b2b.write.pwdata", pwdata, 32'h1234_5678);
      step();
      ctl("b2b.wen", 3'b100, 1'b1, 1'b1, 1'b1);
      valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0000; prdata = 32'hCAFE;
      step(); valid = 1'b0; #1;
      ctl("b2b.read", 3'b001, 1'b0, 1'b0, 1'b0);
      chk("b2b.read.paddr", paddr, 32'h8000_0000);
      step();
      ctl("b2b.ren", 3'b001, 1'b1, 1'b0, 1'b1);
      chk("b2b.ren.hrdata", hrdata, 32'hCAFE);
      step();
      ctl("b2b.idle", 3'b000, 1'b0, 1'b0, 1'b1);

      // misses: above, just past the last window, below the first window
      valid = 1'b1; hwrite = 1'b0; haddr = 32'h9000_0000;
      step();
      ctl("miss9", 3'b000, 1'b0, 1'b0, 1'b1);
      chk("miss9.paddr", paddr, 32'h8000_0000);
      haddr = 32'h8C00_0000;
      step();
      ctl("miss8c", 3'b000, 1'b0, 1'b0, 1'b1);
      haddr = 32'h7FFF_FFFF; hwrite = 1'b1;
      step();
      ctl("miss7f", 3'b000, 1'b0, 1'b0, 1'b1);

      // top address of the third window still hits
      hwrite = 1'b0; haddr = 32'h8BFF_FFFF; prdata = 32'h0BAD_F00D;
      step(); valid = 1'b0; #1;
      ctl("edge.read", 3'b100, 1'b0, 1'b0, 1'b0);
      step();
      chk("edge.ren.hrdata", hrdata, 32'h0BAD_F00D);
      step();

      // reset during WRITE aborts the transfer
      valid = 1'b1; hwrite = 1'b1; haddr = 32'h8400_0000;
      step(); valid = 1'b0; hwdata = 32'h11; #1;
      step();
      ctl("ra.write", 3'b010, 1'b0, 1'b1, 1'b0);
      hreset = 1'b1; #1;
      ctl("ra.rst", 3'b000, 1'b0, 1'b0, 1'b1);
      chk("ra.rst.paddr",  paddr,  32'h0);
      chk("ra.rst.pwdata", pwdata, 32'h0);
      step();
      ctl("ra.hold", 3'b000, 1'b0, 1'b0, 1'b1);
      hreset = 1'b0;
      valid = 1'b1; hwrite = 1'b0; haddr = 32'h8000_0000; prdata = 32'h77;
      step(); valid = 1'b0; #1;
      ctl("ra.read", 3'b001, 1'b0, 1'b0, 1'b0);
      step();
      ctl("ra.ren", 3'b001, 1'b1, 1'b0, 1'b1);
      chk("ra.ren.hrdata", hrdata, 32'h77);
      step();
      ctl("ra.idle", 3'b000, 1'b0, 1'b0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
